dcache_responder: RTL and testbench
===================================

# dcache_responder

Single-port, direct-mapped, write-back/write-allocate data cache that answers the memory stage's shared request port (Wen, Ren, Addr, WriteData, ReadData). Hits complete in the same cycle; misses raise Stall while an FSM writes back a dirty victim line and refills from backing memory over a word-serial req/ack bus. It sits between the dual-issue pipeline's memory stage and main memory.

## Interface
- SETS, 64, number of lines (power of two)
- WORDS, 4, 32-bit words per line (power of two, ≥2)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Wen  in  1  store request from memory stage
- Ren  in  1  load request from memory stage
- Addr  in  32  byte address; bits [1:0] ignored
- WriteData  in  32  store data
- ReadData  out  32  load data, valid when Ren & ~Stall
- Stall  out  1  access not complete; pipeline must hold Wen/Ren/Addr/WriteData stable
- mem_req  out  1  backing-memory beat request
- mem_we  out  1  1 = write beat, 0 = read beat
- mem_addr  out  32  word-aligned beat address
- mem_wdata  out  32  write-beat data
- mem_rdata  in  32  read-beat data, valid with mem_ack
- mem_ack  in  1  beat accepted/completed this cycle

## Operation
- Address split: offset [log2(WORDS)+1:2], index next log2(SETS) bits, tag remainder.
- Per line: valid, dirty, tag, WORDS data words.
- States: IDLE, WRITEBACK, REFILL.
- IDLE, access = Wen|Ren. Hit = valid & tag match.
  - Read hit: ReadData = data[index][offset] combinationally; Stall 0.
  - Write hit: word written at clock edge, dirty set; Stall 0.
  - Miss: Stall 1; go WRITEBACK if victim valid & dirty, else REFILL; beat counter cleared.
- Wen & Ren both high: treated as write; ReadData don't-care.
- WRITEBACK: mem_req 1, mem_we 1, mem_addr = {victim tag, index, beat, 2'b00}, mem_wdata = victim word[beat]. On mem_ack beat++; on last ack → REFILL, beat 0.
- REFILL: mem_req 1, mem_we 0, mem_addr = {req tag, index, beat, 2'b00}. On mem_ack mem_rdata written into word[beat], beat++. On last ack: tag written, valid 1, dirty 0, → IDLE.
- Back in IDLE the held access hits and completes normally.
- Wen/Ren dropping mid-miss: current fill finishes, then IDLE.
- Stall = access & (state ≠ IDLE | ~hit).

## Timing
- Reset (async, any state): state IDLE, all valid/dirty 0, beat 0, mem_req 0, mem_we 0; Stall 0 and ReadData 0 while no access. Burst in progress abandoned; dirty data lost.
- mem_addr/mem_we/mem_wdata stable from mem_req rise until mem_ack; mem_req stays high between beats of one burst.
- Zero-wait memory (ack every cycle): clean miss at cycle t → Stall high t..t+WORDS, access completes t+WORDS+1. Dirty miss adds WORDS cycles.
- Wait states extend the current beat only; no timeout.
- Hit latency 0 (combinational read, write at edge).

## Structure
- Package dcache_pkg: state enum (IDLE, WRITEBACK, REFILL), localparam functions for offset/index/tag widths, address-field extract helpers.
- Sub-module dcache_array: tag/valid/dirty/data storage, one read port and one write port (word write with dirty set; line-fill word write; tag/valid/dirty update). Top holds FSM, beat counter and hit logic.

## Test plan
- After reset, Ren Addr 0x100 → Stall 1; read beats 0x100,0x104,0x108,0x10C; Stall drops cycle 5; ReadData = mem[0x100].
- Then Wen 0x104 data 0xDEADBEEF → no stall, no mem_req; next Ren 0x104 returns 0xDEADBEEF.
- Ren 0x504 (index 0x10, new tag) → write beats 0x100..0x10C with 0xDEADBEEF on 0x104, then read beats 0x500..0x50C; Stall 9 cycles.
- mem_ack delayed 3 cycles per beat → mem_addr/mem_wdata unchanged while waiting, Stall held throughout.
- Wen & Ren together on hit, Addr 0x108, data 0x12345678 → line word updated, dirty set, no stall.
- rst_n low mid-refill → mem_req 0 immediately; after release, Ren 0x100 misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding, field widths and address-field helpers for the data cache
package dcache_pkg;
    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_e;
    function automatic int off_w(int words);
        return $clog2(words);
    endfunction
    function automatic int idx_w(int sets);
        return $clog2(sets);
    endfunction
    function automatic int tag_w(int sets, int words);
        return 30 - $clog2(sets) - $clog2(words);
    endfunction
    function automatic logic [31:0] addr_off(logic [31:0] a, int words);
        return (a >> 2) & 32'(words - 1);
    endfunction
    function automatic logic [31:0] addr_idx(logic [31:0] a, int sets, int words);
        return (a >> (2 + $clog2(words))) & 32'(sets - 1);
    endfunction
    function automatic logic [31:0] addr_tag(logic [31:0] a, int sets, int words);
        return a >> (2 + $clog2(words) + $clog2(sets));
    endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: per-line valid/dirty/tag/data storage with one read port and one write port
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int WORDS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [idx_w(SETS)-1:0]               idx,
    input  logic [off_w(WORDS)-1:0]              off,
    input  logic [31:0]                          wdata,
    input  logic [tag_w(SETS, WORDS)-1:0]        tag_in,
    input  logic                                 word_we,
    input  logic                                 fill_we,
    input  logic                                 meta_we,
    output logic                                 line_valid,
    output logic                                 line_dirty,
    output logic [tag_w(SETS, WORDS)-1:0]        line_tag,
    output logic [WORDS-1:0][31:0]               line
);
    logic [SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [tag_w(SETS, WORDS)-1:0] tag_mem [SETS];
    logic [WORDS-1:0][31:0] data_mem [SETS];

    // a completed fill marks the line valid and clean; a store hit marks it dirty
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (meta_we) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end
        if (word_we) dirty_d[idx] = 1'b1;
    end

    // line status is cleared by reset so every line starts invalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // tag and data storage needs no reset; valid gates every use
    always_ff @(posedge clk) begin
        if (word_we | fill_we) data_mem[idx][off] <= wdata;
        if (meta_we) tag_mem[idx] <= tag_in;
    end

    assign line_valid = valid_q[idx];
    assign line_dirty = dirty_q[idx];
    assign line_tag   = tag_mem[idx];
    assign line       = data_mem[idx];
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-back data cache with word-serial miss handling
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Wen,
    input  logic        Ren,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int OW = off_w(WORDS);
    localparam int IW = idx_w(SETS);
    localparam int TW = tag_w(SETS, WORDS);

    state_e state_q, state_d;
    logic [OW-1:0] beat_q, beat_d;
    logic [TW-1:0] mtag_q, mtag_d;
    logic [IW-1:0] midx_q, midx_d;
    logic [OW-1:0] req_off, off;
    logic [IW-1:0] req_idx, idx;
    logic [TW-1:0] req_tag, line_tag;
    logic [31:0] wdata;
    logic [WORDS-1:0][31:0] line;
    logic idle, access, hit, last, line_valid, line_dirty, word_we, fill_we, meta_we;

    assign req_off  = OW'(addr_off(Addr, WORDS));
    assign req_idx  = IW'(addr_idx(Addr, SETS, WORDS));
    assign req_tag  = TW'(addr_tag(Addr, SETS, WORDS));
    assign idle     = state_q == IDLE;
    assign access   = Wen | Ren;
    assign idx      = idle ? req_idx : midx_q;
    assign off      = idle ? req_off : beat_q;
    assign wdata    = idle ? WriteData : mem_rdata;
    assign hit      = line_valid & (line_tag == req_tag);
    assign last     = &beat_q;
    assign Stall    = access & (~idle | ~hit);
    assign ReadData = Ren ? line[req_off] : '0;

    dcache_array #(.SETS(SETS), .WORDS(WORDS)) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx),
        .off        (off),
        .wdata      (wdata),
        .tag_in     (mtag_q),
        .word_we    (word_we),
        .fill_we    (fill_we),
        .meta_we    (meta_we),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line       (line)
    );

    // miss FSM: the missing line address is latched so a dropped request still finishes its fill
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        mtag_d    = mtag_q;
        midx_d    = midx_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        word_we   = 1'b0;
        fill_we   = 1'b0;
        meta_we   = 1'b0;
        case (state_q)
            IDLE: begin
                word_we = Wen & hit;
                if (access & ~hit) begin
                    state_d = (line_valid & line_dirty) ? WRITEBACK : REFILL;
                    beat_d  = '0;
                    mtag_d  = req_tag;
                    midx_d  = req_idx;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line_tag, midx_q, beat_q, 2'b00};
                mem_wdata = line[beat_q];
                if (mem_ack) begin
                    beat_d  = beat_q + 1'b1;
                    state_d = last ? REFILL : WRITEBACK;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {mtag_q, midx_q, beat_q, 2'b00};
                fill_we  = mem_ack;
                if (mem_ack) begin
                    beat_d  = beat_q + 1'b1;
                    meta_we = last;
                    state_d = last ? IDLE : REFILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, beat counter and latched miss address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            mtag_q  <= '0;
            midx_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            mtag_q  <= mtag_d;
            midx_q  <= midx_d;
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: randomized check of the data cache against a memory-view reference model
module tb_dcache_responder;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n, Wen, Ren, Stall, mem_req, mem_we, mem_ack;
    logic [31:0] Addr, WriteData, ReadData, mem_addr, mem_wdata, mem_rdata;

    typedef struct {logic [31:0] a; logic we; logic [31:0] wd;} beat_t;
    beat_t beats[$];

    logic [31:0] view [4096];
    logic [31:0] bmem [4096];
    int  mtag [64];
    bit  mval [64];
    bit  mdirty [64];
    int  waits = 0;
    int  n_vec = 0;
    int  n_err = 0;

    dcache_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Wen       (Wen),
        .Ren       (Ren),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // backing memory: acks each beat after 'waits' wait cycles and logs every completed beat
    initial begin
        int wcnt = 0;
        logic [31:0] cap_a = '0, cap_wd = '0;
        logic cap_we = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst_n || !mem_req) wcnt = 0;
            else begin
                if (wcnt == 0) begin
                    cap_a = mem_addr;
                    cap_we = mem_we;
                    cap_wd = mem_wdata;
                end else begin
                    chk("hold_addr", mem_addr, cap_a);
                    chk("hold_we", 32'(mem_we), 32'(cap_we));
                    if (cap_we) chk("hold_wdata", mem_wdata, cap_wd);
                end
                if (wcnt >= waits) begin
                    mem_ack = 1'b1;
                    wcnt = 0;
                    beats.push_back('{mem_addr, mem_we, mem_wdata});
                    if (mem_we) bmem[mem_addr[13:2]] = mem_wdata;
                    else mem_rdata = bmem[mem_addr[13:2]];
                end else wcnt++;
            end
        end
    end

    task automatic access(input bit we, input bit re, input logic [31:0] a, input logic [31:0] wd, input int w);
        int idx, tag, wi, cyc, exp_cyc, n;
        bit hit, dirty;
        logic [31:0] ea[$];
        bit ewe[$];
        logic [31:0] ewd[$];
        idx = int'(a[9:4]);
        tag = int'(a[31:10]);
        wi = int'(a[13:2]);
        hit = mval[idx] && mtag[idx] == tag;
        dirty = !hit && mval[idx] && mdirty[idx];
        for (int b = 0; b < WORDS && dirty; b++) begin
            ea.push_back(32'((mtag[idx] << 10) | (idx << 4) | (b << 2)));
            ewe.push_back(1'b1);
            ewd.push_back(view[(mtag[idx] << 8) | (idx << 2) | b]);
        end
        for (int b = 0; b < WORDS && !hit; b++) begin
            ea.push_back(32'((tag << 10) | (idx << 4) | (b << 2)));
            ewe.push_back(1'b0);
            ewd.push_back('0);
        end
        exp_cyc = hit ? 0 : 1 + (dirty ? 2 : 1) * WORDS * (w + 1);
        waits = w;
        beats.delete();
        @(posedge clk);
        #1;
        Wen = we;
        Ren = re;
        Addr = a;
        WriteData = wd;
        cyc = 0;
        @(negedge clk);
        while (Stall && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(cyc), 32'(exp_cyc));
        if (re && !we) chk("rdata", ReadData, view[wi]);
        chk("beat_count", 32'(beats.size()), 32'(ea.size()));
        n = beats.size() < ea.size() ? beats.size() : ea.size();
        for (int i = 0; i < n; i++) begin
            chk("beat_addr", beats[i].a, ea[i]);
            chk("beat_we", 32'(beats[i].we), 32'(ewe[i]));
            if (ewe[i]) chk("beat_wdata", beats[i].wd, ewd[i]);
        end
        if (!hit) begin
            mval[idx] = 1'b1;
            mtag[idx] = tag;
            mdirty[idx] = 1'b0;
        end
        if (we) begin
            view[wi] = wd;
            mdirty[idx] = 1'b1;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        Wen = 1'b0;
        Ren = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(Stall), 32'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mval[i] = 1'b0;
            mdirty[i] = 1'b0;
            mtag[i] = 0;
        end
        for (int i = 0; i < 4096; i++) view[i] = bmem[i];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            bmem[i] = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
        end
        model_reset();
        rst_n = 1'b0;
        Wen = 1'b0;
        Ren = 1'b0;
        Addr = '0;
        WriteData = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        rst_n = 1'b1;
        idle_cycle();
        access(1'b0, 1'b1, 32'h100, '0, 0);
        access(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 0);
        access(1'b0, 1'b1, 32'h104, '0, 0);
        access(1'b0, 1'b1, 32'h504, '0, 0);
        access(1'b0, 1'b1, 32'h100, '0, 3);
        access(1'b1, 1'b1, 32'h108, 32'h12345678, 0);
        access(1'b0, 1'b1, 32'h108, '0, 0);
        // reset in the middle of a refill burst
        waits = 1;
        @(posedge clk);
        #1;
        Wen = 1'b0;
        Ren = 1'b1;
        Addr = 32'h2200;
        repeat (4) @(posedge clk);
        #1;
        chk("refill_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_we", 32'(mem_we), 32'd0);
        Ren = 1'b0;
        @(negedge clk);
        chk("rst_noacc_stall", 32'(Stall), 32'd0);
        chk("rst_noacc_rdata", ReadData, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        access(1'b0, 1'b1, 32'h100, '0, 0);
        access(1'b0, 1'b1, 32'h108, '0, 0);
        for (int k = 0; k < 300; k++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 4);
            a = 32'($urandom_range(0, 32'h3FFF));
            if (op == 4) idle_cycle();
            else access(op == 1 || op == 2, op != 1, a, $urandom, $urandom_range(0, 2));
        end
        idle_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
